// File: rtl/regfile_dump_reader_pkg.sv
// Shared definitions for the register-file dump reader.
// Holds the FSM state encoding and the default geometry of the 32x64
// register file. The register file itself uses the same geometry.
package regfile_dump_reader_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_DEPTH  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : regfile_dump_reader_pkg

// File: rtl/regfile_dump_reader_if.sv
// Output stream of the dump reader: one register word per beat, together
// with its address and an end-of-dump marker.
//
// Handshake: the master raises out_valid with out_data/out_addr/out_last.
// While out_valid is high those fields stay stable. A beat transfers on a
// rising clock edge where out_valid and out_ready are both high. The slave
// may drive out_ready independently of out_valid.
//
// Modports:
//   master : drives out_valid, out_data, out_addr, out_last; reads out_ready
//   slave  : reads out_valid, out_data, out_addr, out_last; drives out_ready
interface regfile_dump_reader_if
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );

endinterface : regfile_dump_reader_if

// File: rtl/regfile_dump_reader.sv
// Read-side initiator for the register file. A start command latches a
// wrap-around address range. The block then walks that range on one
// regfile read port and streams each word out with its address. The final
// word carries out_last, and done pulses once after that word is accepted.
//
// Ports:
//   clk, reset       clock; asynchronous active-low reset
//   start            one-cycle dump request, honoured only in IDLE
//   first_addr       first register of the range, sampled with start
//   last_addr        final register of the range, sampled with start
//   abort            synchronous cancel while a dump runs
//   rd_addr          regfile read-port address
//   rd_data          regfile read data, combinational from rd_addr
//   out_if           output stream (master side)
//   busy             high while the FSM is in RUN
//   done             one-cycle pulse after the last word is accepted
//   fsm_state        current FSM state, exported for observation
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  input  logic                  abort,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  regfile_dump_reader_if.master out_if,
  output logic                  busy,
  output logic                  done,
  output state_t                fsm_state
);

  state_t              state_q;
  state_t              state_d;

  // One bit wider than the address so that a full 32-word dump is encodable.
  logic [ADDR_W:0]     remaining;

  logic                out_valid_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_addr_q;

  logic                take_start;
  logic                take_abort;
  logic                handshake;
  logic                finish;
  logic                load;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode. abort overrides fetching and completion
  // in the same cycle.
  always_comb begin
    take_start = 1'b0;
    take_abort = 1'b0;
    handshake  = out_valid_q && out_if.out_ready;
    finish     = 1'b0;
    load       = 1'b0;
    state_d    = state_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          take_abort = 1'b1;
          state_d    = IDLE;
        end else begin
          // Fetch when the output register is empty or is being drained.
          load   = (remaining != '0) && (!out_valid_q || out_if.out_ready);
          finish = handshake && out_last_q;
          if (finish) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address counter, remaining counter and output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr     <= '0;
      remaining   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (take_start) begin
        rd_addr <= first_addr;
        // The subtraction wraps at ADDR_W bits, so wrap-around ranges count correctly.
        remaining <= {1'b0, last_addr - first_addr} + {{ADDR_W{1'b0}}, 1'b1};
      end else if (take_abort) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        remaining   <= '0;
      end else if (load) begin
        out_data_q  <= rd_data;
        out_addr_q  <= rd_addr;
        out_last_q  <= (remaining == {{ADDR_W{1'b0}}, 1'b1});
        out_valid_q <= 1'b1;
        rd_addr     <= rd_addr + 1'b1;
        remaining   <= remaining - 1'b1;
      end else if (handshake) begin
        // Drained with nothing left to fetch. rd_addr keeps its post-increment value.
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        done        <= finish;
      end
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_addr  = out_addr_q;
  assign out_if.out_last  = out_last_q;

  assign busy      = (state_q == RUN);
  assign fsm_state = state_q;

endmodule : regfile_dump_reader

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader. A behavioural 32x64 register file drives
// rd_data. Each dump pushes its expected beats, computed from the address
// range and the register contents, into a queue. A monitor pops and checks
// the queue on every accepted beat. It also checks that a presented beat
// holds its expected value while stalled, and that done pulses exactly
// once after the last beat is accepted.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int EW = DW + AW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start;
  logic          abort;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  state_t        fsm_state;

  regfile_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) out_if ();

  logic [DW-1:0] regs [32];
  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .abort      (abort),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_if     (out_if),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int acc_cnt     = 0;
  int done_cnt    = 0;
  int dumps_done  = 0;
  bit done_exp    = 1'b0;
  int ready_mode  = 0;   // 0 high, 1 pattern 1,0,0, 2 random, 3 manual
  int cyc         = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    out_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       out_if.out_ready = 1'b1;
        1:       out_if.out_ready = (cyc % 3 == 0);
        2:       out_if.out_ready = ($urandom_range(0, 1) == 1);
        default: ;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [EW-1:0] got;
    forever begin
      @(negedge clk);
      if (!reset) begin
        done_exp = 1'b0;
      end else begin
        vectors++;
        if (done !== done_exp) begin
          miscompares++;
          $display("FAIL done_pulse got=%b expected=%b", done, done_exp);
        end
        if (done_exp) begin
          vectors++;
          if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_at_done got=%b expected=0", busy);
          end
        end
        if (done) done_cnt++;
        done_exp = 1'b0;
        if (out_if.out_valid) begin
          got = {out_if.out_data, out_if.out_addr, out_if.out_last};
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_beat got addr=%0d data=%h", out_if.out_addr, out_if.out_data);
          end else begin
            if (got !== exp_q[0]) begin
              miscompares++;
              $display("FAIL beat got addr=%0d data=%h last=%b expected addr=%0d data=%h last=%b",
                       got[AW:1], got[EW-1:AW+1], got[0],
                       exp_q[0][AW:1], exp_q[0][EW-1:AW+1], exp_q[0][0]);
            end
            if (out_if.out_ready) begin
              done_exp = exp_q[0][0];
              void'(exp_q.pop_front());
              acc_cnt++;
            end
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // A dump covers first..last, incrementing modulo 32. Each word carries
  // the register contents current when it is fetched.
  task automatic push_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    logic [AW-1:0] span;
    logic [AW-1:0] a;
    int n;
    span = l - f;
    n = int'(span) + 1;
    for (int k = 0; k < n; k++) begin
      a = f + AW'(k);
      exp_q.push_back({regs[a], a, (k == n - 1)});
    end
  endtask

  // Write while the stream is stalled: the presented beat is already
  // captured, and every later beat is still unfetched.
  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [EW-1:0] e;
    regs[a] = d;
    for (int j = 1; j < exp_q.size(); j++) begin
      e = exp_q[j];
      if (e[AW:1] == a) begin
        e[EW-1:AW+1] = d;
        exp_q[j] = e;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input bit with_abort);
    @(posedge clk);
    #2;
    acc_cnt = 0;
    push_dump(f, l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    abort      = with_abort;
    @(posedge clk);
    #2;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    dumps_done++;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= dumps_done) break;
    end
    chk("done_count", 64'(done_cnt), 64'(dumps_done));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("state_idle", 64'(fsm_state), 64'(IDLE));
  endtask

  task automatic wait_acc(input int n, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (acc_cnt >= n) break;
      @(posedge clk);
    end
    if (acc_cnt < n) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout got=%0d expected=%0d", acc_cnt, n);
    end
    #2;
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 32; i++) regs[i] = {$urandom(), $urandom()};
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    for (int i = 0; i < 32; i++) regs[i] = 64'h1000_0000_0000_0000 + 64'(i);

    // Reset values
    #3;
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_out_valid", 64'(out_if.out_valid), 64'd0);
    chk("rst_out_data", out_if.out_data, 64'd0);
    chk("rst_out_addr", 64'(out_if.out_addr), 64'd0);
    chk("rst_out_last", 64'(out_if.out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Full range, ready held high; check single-cycle throughput
    ready_mode = 0;
    start_dump(5'd0, 5'd31, 1'b0);
    #1;
    chk("busy_after_start", 64'(busy), 64'd1);
    wait_done(80);

    // Wrap-around range with ready pattern 1,0,0
    ready_mode = 1;
    start_dump(5'd30, 5'd1, 1'b0);
    wait_done(60);

    // Single-word range
    ready_mode = 0;
    start_dump(5'd7, 5'd7, 1'b0);
    wait_done(20);

    // Snapshot: stall on beat 3, then write registers 3 and 9
    ready_mode = 3;
    out_if.out_ready = 1'b1;
    start_dump(5'd0, 5'd15, 1'b0);
    wait_acc(3, 40);
    out_if.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("stall_addr", 64'(out_if.out_addr), 64'd3);
    model_write(5'd3, 64'hDEAD);
    model_write(5'd9, 64'hBEEF);
    repeat (3) @(posedge clk);
    #2;
    ready_mode = 0;
    wait_done(60);

    // Stray start during a dump has no effect
    randomize_regs();
    ready_mode = 2;
    start_dump(5'd10, 5'd20, 1'b0);
    wait_acc(3, 100);
    first_addr = 5'd0;
    last_addr  = 5'd31;
    start      = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(200);

    // Abort after the 5th accepted beat
    ready_mode = 0;
    start_dump(5'd0, 5'd15, 1'b0);
    wait_acc(5, 40);
    ready_mode = 3;
    out_if.out_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(out_if.out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_no_done", 64'(done_cnt), 64'(dumps_done));
    exp_q.delete();
    // abort in IDLE is ignored
    @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    // start and abort together in IDLE: start wins
    ready_mode = 0;
    start_dump(5'd20, 5'd22, 1'b1);
    wait_done(20);

    // Randomized ranges and backpressure
    for (int t = 0; t < 6; t++) begin
      logic [AW-1:0] f;
      logic [AW-1:0] l;
      randomize_regs();
      f = AW'($urandom_range(0, 31));
      l = AW'($urandom_range(0, 31));
      ready_mode = int'($urandom_range(0, 2));
      start_dump(f, l, 1'b0);
      wait_done(400);
    end

    // Asynchronous reset mid-dump
    ready_mode = 0;
    start_dump(5'd0, 5'd31, 1'b0);
    wait_acc(4, 40);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_rd_addr", 64'(rd_addr), 64'd0);
    chk("arst_out_valid", 64'(out_if.out_valid), 64'd0);
    chk("arst_out_data", out_if.out_data, 64'd0);
    chk("arst_out_addr", 64'(out_if.out_addr), 64'd0);
    chk("arst_out_last", 64'(out_if.out_last), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    start_dump(5'd4, 5'd6, 1'b0);
    wait_done(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regfile_dump_reader
